// File: rtl/mult_issue_ctrl.sv
// Issue controller for a 4x4 sequential multiplier: accepts an operand pair, pulses START,
// waits for a qualified READY (or times out), then holds the registered product until accepted.
module mult_issue_ctrl #(
  parameter int START_CYCLES = 2,
  parameter int TIMEOUT      = 31
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_a,
  input  logic [3:0] in_b,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_p,
  output logic       err,
  output logic [7:0] done_cnt,
  output logic       mul_start,
  output logic [3:0] mul_a,
  output logic [3:0] mul_b,
  input  logic       mul_ready,
  input  logic [7:0] mul_p
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [7:0] START_LAST = 8'(START_CYCLES - 1);
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t     state_q;
  logic [7:0] cnt_q;
  logic       in_ready_q;
  logic       out_valid_q;
  logic [7:0] out_p_q;
  logic       err_q;
  logic [7:0] done_cnt_q;
  logic       mul_start_q;
  logic [3:0] mul_a_q;
  logic [3:0] mul_b_q;

  logic [7:0] cnt_d;
  logic       ready_qual_d;

  // READY seen on the first RUN cycle may be left over from the previous operation.
  assign cnt_d        = cnt_q + 8'd1;
  assign ready_qual_d = mul_ready && (cnt_q != 8'd0);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_p_q     <= 8'd0;
      err_q       <= 1'b0;
      done_cnt_q  <= 8'd0;
      mul_start_q <= 1'b0;
      mul_a_q     <= 4'd0;
      mul_b_q     <= 4'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            mul_a_q     <= in_a;
            mul_b_q     <= in_b;
            cnt_q       <= 8'd0;
            in_ready_q  <= 1'b0;
            mul_start_q <= 1'b1;
            state_q     <= S_START;
          end
        end
        S_START: begin
          if (cnt_q == START_LAST) begin
            cnt_q       <= 8'd0;
            mul_start_q <= 1'b0;
            state_q     <= S_RUN;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_RUN: begin
          cnt_q <= cnt_d;
          // A real product arriving on the timeout cycle takes precedence over the error path.
          if (ready_qual_d) begin
            out_p_q     <= mul_p;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else if (cnt_q == TIMEOUT_CNT) begin
            out_p_q     <= 8'h00;
            out_valid_q <= 1'b1;
            err_q       <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            done_cnt_q  <= done_cnt_q + 8'd1;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_p     = out_p_q;
  assign err       = err_q;
  assign done_cnt  = done_cnt_q;
  assign mul_start = mul_start_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// Randomized self-checking bench for mult_issue_ctrl; a transaction-level model predicts
// capture cycle, product/timeout result, err and done_cnt from the operation parameters.
module tb_mult_issue_ctrl;

  localparam int S  = 2;
  localparam int TO = 31;

  logic       clock = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_p;
  logic       err;
  logic [7:0] done_cnt;
  logic       mul_start;
  logic [3:0] mul_a;
  logic [3:0] mul_b;
  logic       mul_ready;
  logic [7:0] mul_p;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] done_exp = 8'd0;
  logic       err_exp = 1'b0;

  mult_issue_ctrl #(.START_CYCLES(S), .TIMEOUT(TO)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .err       (err),
    .done_cnt  (done_cnt),
    .mul_start (mul_start),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_ready (mul_ready),
    .mul_p     (mul_p)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_p", out_p, 0);
    check("rst_err", err, 0);
    check("rst_done_cnt", done_cnt, 0);
    check("rst_mul_start", mul_start, 0);
    check("rst_mul_a", mul_a, 0);
    check("rst_mul_b", mul_b, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    done_exp = 8'd0;
    err_exp  = 1'b0;
    check_reset_values();
  endtask

  // One operation. READY rises at RUN cycle d and stays up; a stale READY can also
  // appear on RUN cycle 0. d > TO means the multiplier never answers.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input int d,
                        input bit stale, input int stall, output int gap);
    int         kexp;
    bit         tmo;
    logic [7:0] prod;
    logic [7:0] pexp;
    prod = {4'b0, a} * {4'b0, b};
    tmo  = (d > TO);
    kexp = tmo ? TO : ((d < 1) ? 1 : d);
    pexp = tmo ? 8'h00 : prod;
    gap  = 0;
    check("idle_in_ready", in_ready, 1);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    @(negedge clock);
    for (int i = 0; i < S; i++) begin
      check("start_mul_start", mul_start, 1);
      check("start_in_ready", in_ready, 0);
      check("start_mul_a", mul_a, a);
      check("start_mul_b", mul_b, b);
      gap++;
      mul_ready = stale;
      mul_p     = 8'($urandom);
      in_valid  = 1'($urandom_range(0, 1));
      in_a      = 4'($urandom);
      in_b      = 4'($urandom);
      @(negedge clock);
    end
    for (int k = 0; k <= kexp; k++) begin
      check("run_mul_start", mul_start, 0);
      check("run_out_valid", out_valid, 0);
      check("run_in_ready", in_ready, 0);
      check("run_mul_a", mul_a, a);
      check("run_mul_b", mul_b, b);
      gap++;
      mul_ready = (k >= d) || (k == 0 && stale);
      mul_p     = (k >= d) ? prod : 8'($urandom);
      in_valid  = 1'($urandom_range(0, 1));
      in_a      = 4'($urandom);
      in_b      = 4'($urandom);
      @(negedge clock);
    end
    if (tmo) err_exp = 1'b1;
    for (int s = 0; s <= stall; s++) begin
      check("done_out_valid", out_valid, 1);
      check("done_out_p", out_p, pexp);
      check("done_err", err, err_exp);
      check("done_in_ready", in_ready, 0);
      check("done_mul_a", mul_a, a);
      check("done_mul_b", mul_b, b);
      check("done_cnt_hold", done_cnt, done_exp);
      gap++;
      out_ready = (s == stall);
      in_valid  = 1'($urandom_range(0, 1));
      mul_ready = 1'($urandom_range(0, 1));
      mul_p     = 8'($urandom);
      @(negedge clock);
    end
    done_exp = done_exp + 8'd1;
    check("post_out_valid", out_valid, 0);
    check("post_in_ready", in_ready, 1);
    check("post_done_cnt", done_cnt, done_exp);
    check("post_err", err, err_exp);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    mul_ready = 1'b0;
    $display("op a=%0d b=%0d d=%0d stale=%0d stall=%0d exp_p=%02h got_p=%02h err=%0d done=%0d gap=%0d",
             a, b, d, stale, stall, pexp, out_p, err, done_cnt, gap);
  endtask

  // Accept an operation, advance cyc cycles into it, then reset together with live handshakes.
  task automatic abort_op(input logic [3:0] a, input logic [3:0] b, input int cyc,
                          input bit in_done);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    @(negedge clock);
    in_valid  = 1'b0;
    mul_ready = 1'b1;
    mul_p     = {4'b0, a} * {4'b0, b};
    out_ready = 1'b0;
    repeat (cyc - 1) @(negedge clock);
    check("abort_out_valid_pre", out_valid, in_done);
    reset     = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clock);
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    mul_ready = 1'b0;
    done_exp  = 8'd0;
    err_exp   = 1'b0;
    check_reset_values();
    $display("abort a=%0d b=%0d after %0d cycles in_done=%0d done=%0d", a, b, cyc, in_done, done_cnt);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap;
    reset = 1'b1; in_valid = 1'b0; in_a = 4'd0; in_b = 4'd0;
    out_ready = 1'b0; mul_ready = 1'b0; mul_p = 8'd0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check_reset_values();

    run_op(4'd3, 4'd5, 10, 1'b0, 0, gap);
    run_op(4'd15, 4'd15, 3, 1'b0, 20, gap);
    run_op(4'd7, 4'd9, 4, 1'b1, 0, gap);

    abort_op(4'd9, 4'd9, S + 2, 1'b0);
    abort_op(4'd5, 4'd11, S + 4, 1'b1);
    run_op(4'd6, 4'd7, 5, 1'b1, 1, gap);

    run_op(4'd13, 4'd11, TO, 1'b1, 0, gap);
    check("coincident_no_err", err, 0);
    run_op(4'd4, 4'd4, 255, 1'b0, 2, gap);
    run_op(4'd2, 4'd7, 2, 1'b0, 0, gap);
    check("err_sticky", err, 1);

    for (int n = 0; n < 40; n++) begin
      run_op(4'($urandom), 4'($urandom), int'($urandom_range(0, 40)),
             1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), gap);
    end

    do_reset();
    for (int n = 0; n < 256; n++) begin
      run_op(4'($urandom), 4'($urandom), 1, 1'($urandom_range(0, 1)), 0, gap);
      check("b2b_gap", gap, S + 3);
    end
    check("done_wrap", done_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_issue_ctrl.md
MULT_ISSUE_CTRL -- requirements
Module: mult_issue_ctrl

Interface
REQ-001 Parameter START_CYCLES, default 2, number of cycles mul_start is held high per operation; legal range 1..7.
REQ-002 Parameter TIMEOUT, default 31, maximum RUN cycles allowed before a result is forced; legal range 2..255.
REQ-003 clock  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand pair valid.
REQ-006 in_ready  output  1  block can accept an operand pair.
REQ-007 in_a  input  4  multiplicand.
REQ-008 in_b  input  4  multiplier.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 out_p  output  8  registered product.
REQ-012 err  output  1  sticky timeout flag.
REQ-013 done_cnt  output  8  count of results handed off.
REQ-014 mul_start  output  1  START to the 4x4 sequential multiplier.
REQ-015 mul_a  output  4  A3..A0 to the multiplier.
REQ-016 mul_b  output  4  B3..B0 to the multiplier.
REQ-017 mul_ready  input  1  READY from the multiplier.
REQ-018 mul_p  input  8  P7..P0 from the multiplier.

Function
REQ-019 The FSM SHALL have exactly four states: IDLE, START, RUN and DONE.
REQ-020 IDLE: in_ready=1; when in_valid=1, the block SHALL register in_a/in_b into mul_a/mul_b, clear the cycle counter, and go to START.
REQ-021 in_ready SHALL be 1 only in IDLE.
REQ-022 The in_valid/in_ready handshake SHALL be a single-cycle transfer; operands SHALL NOT be sampled in any other state.
REQ-023 START: mul_start=1 for exactly START_CYCLES consecutive cycles, then go to RUN with the counter cleared.
REQ-024 mul_a and mul_b SHALL remain stable from the acceptance cycle until DONE is exited.
REQ-025 RUN: mul_start=0; the counter SHALL increment by 1 each cycle.
REQ-026 In RUN, mul_ready SHALL be ignored while the counter is 0, which masks a stale READY left from the prior operation.
REQ-027 In RUN with counter>=1 and mul_ready=1, the block SHALL register mul_p into out_p, set out_valid=1, and go to DONE on the next edge.
REQ-028 If RUN reaches counter==TIMEOUT without a qualified mul_ready, the block SHALL set out_p=8'h00, set out_valid=1 and err=1, and go to DONE.
REQ-029 If a qualified mul_ready coincides with counter==TIMEOUT, the valid product SHALL win and err SHALL NOT be set.
REQ-030 DONE: out_valid=1 and out_p held constant until out_ready=1.
REQ-031 On the DONE handshake cycle, out_valid SHALL drop on the next edge, done_cnt SHALL increment, and the FSM SHALL return to IDLE.
REQ-032 A new operand SHALL NOT be accepted in the DONE handshake cycle; minimum spacing between acceptances is START_CYCLES+3 cycles.
REQ-033 done_cnt SHALL be modulo-256 (255 -> 0 wrap) and SHALL count timed-out results too.
REQ-034 err SHALL be sticky; only reset SHALL clear it.
REQ-035 All outputs SHALL be driven from registers; there SHALL be no combinational path from any input to any output.

Reset
REQ-036 While reset=1 at a rising edge, the block SHALL force: state=IDLE, in_ready=1, out_valid=0, out_p=0, err=0, done_cnt=0, mul_start=0, mul_a=0, mul_b=0, counter=0.
REQ-037 Reset SHALL take priority over every handshake in the same cycle.
REQ-038 A reset asserted in START, RUN or DONE SHALL abort the operation, with no result and no done_cnt increment.

Verification
REQ-039 in_a=3, in_b=5 accepted; multiplier model raises READY 10 cycles after START falls with P=15 -> mul_start high exactly 2 cycles, out_p=8'h0F, out_valid=1, done_cnt=1, err=0.
REQ-040 in_a=15, in_b=15 with out_ready held low 20 cycles -> out_p=8'hE1 stable for all 20 cycles, in_ready=0 throughout; on release done_cnt increments once.
REQ-041 Multiplier model holds READY=1 from the prior operation into RUN counter 0 -> not captured; capture only on a later qualified READY with the new product.
REQ-042 Model never raises READY -> at RUN counter 31: out_valid=1, out_p=8'h00, err=1; err stays 1 after the following 2*7=14 operation.
REQ-043 reset pulsed during RUN and during DONE -> all outputs at REQ-036 values next cycle, done_cnt unchanged at 0, next operation 6*7=42 completes normally.
REQ-044 256 back-to-back operations with out_ready tied high -> done_cnt wraps to 0; spacing between in_ready pulses equals START_CYCLES+3 when READY returns at counter 1.
